// File: rtl/range_tracker.sv
// range_tracker: min/max/range of the samples between go and finish, with a sticky error code.
// Optional saturating sample counter enabled by defining RANGE_TRACKER_COUNT_EN.
module range_tracker #(
   parameter int unsigned WIDTH     = 10,
   parameter int unsigned CNT_WIDTH = 8,
   parameter int unsigned SIGNED    = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 valid,
   input  logic                 go,
   input  logic                 finish,
   output logic [WIDTH-1:0]     range,
   output logic [WIDTH-1:0]     min_val,
   output logic [WIDTH-1:0]     max_val,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 done,
   output logic                 busy,
   output logic [1:0]           error
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_FIN_IDLE = 2'b01;
   localparam logic [1:0] ERR_GO_RUN   = 2'b10;
   localparam logic [1:0] ERR_GO_FIN   = 2'b11;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_step;
   logic             w_commit;
   logic [1:0]       w_error_nxt;
   logic             w_lt;
   logic             w_gt;
   logic [WIDTH-1:0] w_acc_min;
   logic [WIDTH-1:0] w_acc_max;
   logic [WIDTH-1:0] r_run_min;
   logic [WIDTH-1:0] r_run_max;
   logic [WIDTH-1:0] r_range;
   logic [WIDTH-1:0] r_min;
   logic [WIDTH-1:0] r_max;
   logic             r_done;
   logic             r_busy;
   logic [1:0]       r_error;

   // Running extremes with this cycle's sample folded in (when valid)
   always_comb begin
      if (SIGNED != 0) begin
         w_lt = $signed(data_in) < $signed(r_run_min);
         w_gt = $signed(data_in) > $signed(r_run_max);
      end else begin
         w_lt = data_in < r_run_min;
         w_gt = data_in > r_run_max;
      end
      w_acc_min = (valid && w_lt) ? data_in : r_run_min;
      w_acc_max = (valid && w_gt) ? data_in : r_run_max;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // go+finish together aborts from either state and discards the session
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_commit    = 1'b0;
      w_error_nxt = r_error;
      if (go && finish) begin
         w_state_nxt = IDLE;
         w_error_nxt = ERR_GO_FIN;
      end else begin
         case (r_state)
            IDLE: begin
               if (go) begin
                  w_load      = 1'b1;
                  w_error_nxt = ERR_NONE;
                  w_state_nxt = RUN;
               end else if (finish) begin
                  w_error_nxt = ERR_FIN_IDLE;
               end
            end
            RUN: begin
               if (go) begin
                  w_load      = 1'b1;
                  w_error_nxt = ERR_GO_RUN;
               end else if (finish) begin
                  w_commit    = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_step = valid;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_run_min <= '0;
         r_run_max <= '0;
         r_range   <= '0;
         r_min     <= '0;
         r_max     <= '0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_error   <= ERR_NONE;
      end else begin
         if (w_load) begin
            r_run_min <= data_in;
            r_run_max <= data_in;
         end else if (w_step) begin
            r_run_min <= w_acc_min;
            r_run_max <= w_acc_max;
         end
         if (w_commit) begin
            r_min   <= w_acc_min;
            r_max   <= w_acc_max;
            r_range <= w_acc_max - w_acc_min;
         end
         r_done  <= w_commit;
         r_busy  <= (w_state_nxt == RUN);
         r_error <= w_error_nxt;
      end
   end

`ifdef RANGE_TRACKER_COUNT_EN
   logic [CNT_WIDTH-1:0] r_run_cnt;
   logic [CNT_WIDTH-1:0] r_count;
   logic [CNT_WIDTH-1:0] w_acc_cnt;

   // Saturate rather than wrap
   assign w_acc_cnt = (valid && (r_run_cnt != {CNT_WIDTH{1'b1}})) ?
                      r_run_cnt + CNT_WIDTH'(1) : r_run_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_run_cnt <= '0;
         r_count   <= '0;
      end else begin
         if (w_load)      r_run_cnt <= CNT_WIDTH'(1);
         else if (w_step) r_run_cnt <= w_acc_cnt;
         if (w_commit)    r_count   <= w_acc_cnt;
      end
   end

   assign count = r_count;
`else
   assign count = '0;
`endif

   assign range   = r_range;
   assign min_val = r_min;
   assign max_val = r_max;
   assign done    = r_done;
   assign busy    = r_busy;
   assign error   = r_error;

endmodule

// File: tb/tb_range_tracker.sv
// Randomized bench for range_tracker: an unsigned (CNT_WIDTH=8) and a signed (CNT_WIDTH=2)
// instance share stimulus and are compared against a sample-list reference model.
module tb_range_tracker;

`ifdef RANGE_TRACKER_COUNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] data_in = '0;
   logic       valid = 1'b0;
   logic       go = 1'b0;
   logic       finish = 1'b0;

   logic [9:0] u_range, u_min, u_max;
   logic [7:0] u_count;
   logic       u_done, u_busy;
   logic [1:0] u_error;
   logic [9:0] s_range, s_min, s_max;
   logic [1:0] s_count;
   logic       s_done, s_busy;
   logic [1:0] s_error;

   range_tracker #(.WIDTH(10), .CNT_WIDTH(8), .SIGNED(0)) u_dut (
      .clock(clock), .reset(reset), .data_in(data_in), .valid(valid), .go(go), .finish(finish),
      .range(u_range), .min_val(u_min), .max_val(u_max), .count(u_count),
      .done(u_done), .busy(u_busy), .error(u_error));

   range_tracker #(.WIDTH(10), .CNT_WIDTH(2), .SIGNED(1)) s_dut (
      .clock(clock), .reset(reset), .data_in(data_in), .valid(valid), .go(go), .finish(finish),
      .range(s_range), .min_val(s_min), .max_val(s_max), .count(s_count),
      .done(s_done), .busy(s_busy), .error(s_error));

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_mis = 0;

   // Reference model state: the current session is simply the list of its samples
   logic [9:0] q[$];
   bit         e_busy, e_done;
   int         e_err;
   logic [9:0] eu_min, eu_max, eu_rng, es_min, es_max, es_rng;
   int         eu_cnt, es_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic summarize(input bit sgn, input int sat, output logic [9:0] mn,
                            output logic [9:0] mx, output logic [9:0] rg, output int cnt);
      int vmin, vmax, v;
      vmin = 0; vmax = 0; mn = '0; mx = '0;
      foreach (q[i]) begin
         v = sgn ? {{22{q[i][9]}}, q[i]} : {22'd0, q[i]};
         if (i == 0 || v < vmin) begin vmin = v; mn = q[i]; end
         if (i == 0 || v > vmax) begin vmax = v; mx = q[i]; end
      end
      rg  = mx - mn;
      cnt = (q.size() > sat) ? sat : q.size();
      if (CNT_ON == 0) cnt = 0;
   endtask

   task automatic model_reset();
      q.delete();
      e_busy = 0; e_done = 0; e_err = 0;
      eu_min = '0; eu_max = '0; eu_rng = '0; eu_cnt = 0;
      es_min = '0; es_max = '0; es_rng = '0; es_cnt = 0;
   endtask

   task automatic model_step(input logic g, input logic f, input logic v, input logic [9:0] d);
      e_done = 0;
      if (g && f) begin
         e_err = 3; e_busy = 0; q.delete();
      end else if (g) begin
         e_err = e_busy ? 2 : 0;
         q.delete(); q.push_back(d); e_busy = 1;
      end else if (f) begin
         if (!e_busy) e_err = 1;
         else begin
            if (v) q.push_back(d);
            summarize(1'b0, 255, eu_min, eu_max, eu_rng, eu_cnt);
            summarize(1'b1, 3, es_min, es_max, es_rng, es_cnt);
            e_done = 1; e_busy = 0;
         end
      end else if (e_busy && v) begin
         q.push_back(d);
      end
   endtask

   task automatic check_all();
      chk("u_done",  32'(u_done),  32'(e_done));
      chk("u_busy",  32'(u_busy),  32'(e_busy));
      chk("u_error", 32'(u_error), 32'(e_err));
      chk("u_min",   32'(u_min),   32'(eu_min));
      chk("u_max",   32'(u_max),   32'(eu_max));
      chk("u_range", 32'(u_range), 32'(eu_rng));
      chk("u_count", 32'(u_count), 32'(eu_cnt));
      chk("s_done",  32'(s_done),  32'(e_done));
      chk("s_busy",  32'(s_busy),  32'(e_busy));
      chk("s_error", 32'(s_error), 32'(e_err));
      chk("s_min",   32'(s_min),   32'(es_min));
      chk("s_max",   32'(s_max),   32'(es_max));
      chk("s_range", 32'(s_range), 32'(es_rng));
      chk("s_count", 32'(s_count), 32'(es_cnt));
   endtask

   task automatic step(input logic g, input logic f, input logic v, input logic [9:0] d);
      @(negedge clock);
      go = g; finish = f; valid = v; data_in = d;
      @(posedge clock);
      model_step(g, f, v, d);
      #1;
      check_all();
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge
   task automatic do_reset();
      @(negedge clock);
      go = 0; finish = 0; valid = 0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [9:0] d;
      logic [9:0] ext[4];
      int r;
      ext[0] = 10'h000; ext[1] = 10'h3FF; ext[2] = 10'h1FF; ext[3] = 10'h200;

      model_reset();
      #3;
      check_all();
      @(negedge clock);
      reset = 1'b0;

      // Unsigned session: 100, 50, 900, 300
      step(1, 0, 0, 10'd100);
      step(0, 0, 1, 10'd50);
      step(0, 0, 1, 10'd900);
      step(0, 0, 1, 10'd300);
      step(0, 1, 0, 10'd0);
      chk("r033_done",  32'(u_done),  32'd1);
      chk("r033_min",   32'(u_min),   32'd50);
      chk("r033_max",   32'(u_max),   32'd900);
      chk("r033_range", 32'(u_range), 32'd850);
      chk("r033_count", 32'(u_count), (CNT_ON != 0) ? 32'd4 : 32'd0);
      chk("r033_error", 32'(u_error), 32'd0);
      step(0, 0, 0, 10'd0);
      chk("r033_pulse", 32'(u_done),  32'd0);

      // Signed session: -1, 5, finish with -512
      step(1, 0, 0, 10'h3FF);
      step(0, 0, 1, 10'h005);
      step(0, 1, 1, 10'h200);
      chk("r034_min",   32'(s_min),   32'h200);
      chk("r034_max",   32'(s_max),   32'h005);
      chk("r034_range", 32'(s_range), 32'd517);
      chk("r034_count", 32'(s_count), (CNT_ON != 0) ? 32'd3 : 32'd0);

      // finish while idle
      step(0, 1, 0, 10'd0);
      chk("r035_error", 32'(s_error), 32'd1);
      chk("r035_done",  32'(s_done),  32'd0);
      chk("r035_hold",  32'(s_min),   32'h200);
      step(1, 0, 0, 10'd5);
      chk("r035_clear", 32'(s_error), 32'd0);
      step(0, 1, 0, 10'd0);

      // go while running restarts with error 10
      step(1, 0, 0, 10'd1);
      step(0, 0, 1, 10'd2);
      step(1, 0, 0, 10'd7);
      chk("r036_error", 32'(u_error), 32'd2);
      chk("r036_busy",  32'(u_busy),  32'd1);
      step(0, 1, 0, 10'd0);
      chk("r036_min",   32'(u_min),   32'd7);
      chk("r036_max",   32'(u_max),   32'd7);
      chk("r036_range", 32'(u_range), 32'd0);
      chk("r036_count", 32'(u_count), (CNT_ON != 0) ? 32'd1 : 32'd0);
      chk("r036_errh",  32'(u_error), 32'd2);

      // go+finish together, then reset mid-session
      step(1, 0, 0, 10'd3);
      step(1, 1, 0, 10'd0);
      chk("r037_error", 32'(u_error), 32'd3);
      chk("r037_busy",  32'(u_busy),  32'd0);
      chk("r037_done",  32'(u_done),  32'd0);
      step(0, 0, 0, 10'd0);
      chk("r037_nodone", 32'(u_done), 32'd0);
      step(1, 0, 0, 10'd9);
      step(0, 0, 1, 10'd4);
      do_reset();
      step(0, 0, 0, 10'd0);
      chk("r037_rdone", 32'(u_done), 32'd0);
      chk("r037_rmin",  32'(u_min),  32'd0);

      // Five samples: signed instance counter saturates at 3
      step(1, 0, 0, 10'd11);
      for (int i = 0; i < 4; i++) step(0, 0, 1, 10'(12 + i));
      step(0, 1, 0, 10'd0);
      chk("r038_sat",   32'(s_count), (CNT_ON != 0) ? 32'd3 : 32'd0);
      chk("r038_nosat", 32'(u_count), (CNT_ON != 0) ? 32'd5 : 32'd0);

      // Randomized traffic with occasional async reset
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         r = $urandom_range(0, 99);
         d = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 3)] : 10'($urandom);
         step(((r < 5) || (r == 50)) ? 1'b1 : 1'b0,
              (((r >= 5) && (r < 12)) || (r == 50)) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
